// File: rtl/bitpack_pkg.sv
// Shared definitions for the bit-pack scheduler: FSM states, coefficient count
// and the width of one packed polynomial word.
package bitpack_pkg;

  localparam int COEFFS = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PACK  = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic int packed_width(input int w);
    return COEFFS * w;
  endfunction

endpackage

// File: rtl/bitpack_sched_simplebitpack.sv
// Combinational packer: coefficient i lands at bits [i*W_WIDTH +: W_WIDTH].
module SimpleBitPack
  import bitpack_pkg::*;
#(
  parameter int W_WIDTH = 4
) (
  input  logic [W_WIDTH-1:0]               coeffs [0:COEFFS-1],
  output logic [packed_width(W_WIDTH)-1:0] packed_word
);

  genvar gi;
  generate
    for (gi = 0; gi < COEFFS; gi++) begin : g_pack
      assign packed_word[gi*W_WIDTH +: W_WIDTH] = coeffs[gi];
    end
  endgenerate

endmodule

// File: rtl/bitpack_sched.sv
// Round-robin scheduler sharing one SimpleBitPack between NREQ encode requesters.
// Optional BITPACK_SCHED_PERF_EN adds saturating stall and completed-job counters.
module bitpack_sched
  import bitpack_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int W_WIDTH = 4,
  parameter  int K_MAX   = 8,
  localparam int OW      = $clog2(NREQ),
  localparam int PW      = packed_width(W_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0][3:0] req_npoly,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 rd_en,
  output logic [OW-1:0]        rd_owner,
  output logic [3:0]           rd_idx,
  input  logic                 rd_valid,
  input  logic [W_WIDTH-1:0]   rd_data [0:COEFFS-1],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        out_data,
  output logic [OW-1:0]        out_owner,
  output logic [3:0]           out_idx,
  output logic                 out_last,
  output logic [NREQ-1:0]      done
`ifdef BITPACK_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_job_cnt
`endif
);

  state_t             state_reg;
  logic [OW-1:0]      rr_ptr_reg;
  logic [OW-1:0]      owner_reg;
  logic [3:0]         npoly_reg;
  logic [3:0]         idx_reg;
  logic               skip_reg;
  logic [NREQ-1:0]    gnt_reg;
  logic [NREQ-1:0]    done_reg;
  logic [W_WIDTH-1:0] coeff_reg [0:COEFFS-1];
  logic [PW-1:0]      packed_word;
  logic [PW-1:0]      out_data_reg;
  logic [OW-1:0]      out_owner_reg;
  logic [3:0]         out_idx_reg;
  logic               out_last_reg;

  logic               any_req;
  logic [OW-1:0]      winner;
  logic [OW-1:0]      rr_next;
  logic [3:0]         npoly_sel;

  // Scan from the farthest slot down so the requester closest to rr_ptr wins.
  always_comb begin
    int c;
    any_req = 1'b0;
    winner  = '0;
    c       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = int'(rr_ptr_reg) + k;
      if (c >= NREQ) c = c - NREQ;
      if (req[c]) begin
        any_req = 1'b1;
        winner  = OW'(c);
      end
    end
  end

  assign rr_next   = (winner == OW'(NREQ - 1)) ? '0 : winner + OW'(1);
  assign npoly_sel = (req_npoly[winner] > 4'(K_MAX)) ? 4'(K_MAX) : req_npoly[winner];

  SimpleBitPack #(.W_WIDTH(W_WIDTH)) u_pack (
    .coeffs      (coeff_reg),
    .packed_word (packed_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      npoly_reg     <= '0;
      idx_reg       <= '0;
      skip_reg      <= 1'b0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      out_data_reg  <= '0;
      out_owner_reg <= '0;
      out_idx_reg   <= '0;
      out_last_reg  <= 1'b0;
      for (int i = 0; i < COEFFS; i++) coeff_reg[i] <= '0;
    end else begin
      gnt_reg  <= '0;
      done_reg <= '0;
      case (state_reg)
        IDLE: begin
          // A zero-length job parks here one cycle so done follows gnt without arbitrating.
          if (skip_reg) begin
            skip_reg <= 1'b0;
            done_reg <= NREQ'(1) << owner_reg;
          end else if (any_req) begin
            gnt_reg    <= NREQ'(1) << winner;
            owner_reg  <= winner;
            npoly_reg  <= npoly_sel;
            rr_ptr_reg <= rr_next;
            idx_reg    <= '0;
            if (npoly_sel == 4'd0) skip_reg  <= 1'b1;
            else                   state_reg <= FETCH;
          end
        end
        FETCH: begin
          if (rd_valid) begin
            for (int i = 0; i < COEFFS; i++) coeff_reg[i] <= rd_data[i];
            state_reg <= PACK;
          end
        end
        PACK: begin
          out_data_reg  <= packed_word;
          out_owner_reg <= owner_reg;
          out_idx_reg   <= idx_reg;
          out_last_reg  <= (idx_reg == npoly_reg - 4'd1);
          state_reg     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            if (out_last_reg) begin
              state_reg <= IDLE;
              done_reg  <= NREQ'(1) << owner_reg;
            end else begin
              idx_reg   <= idx_reg + 4'd1;
              state_reg <= FETCH;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != IDLE) || skip_reg;
  assign rd_en     = (state_reg == FETCH);
  assign rd_owner  = owner_reg;
  assign rd_idx    = idx_reg;
  assign out_valid = (state_reg == OUT);
  assign out_data  = out_data_reg;
  assign out_owner = out_owner_reg;
  assign out_idx   = out_idx_reg;
  assign out_last  = out_last_reg;

`ifdef BITPACK_SCHED_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] job_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
      job_cnt_reg   <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if ((|done_reg) && (job_cnt_reg != '1))               job_cnt_reg   <= job_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_reg;
  assign perf_job_cnt   = job_cnt_reg;
`endif

endmodule

// File: tb/tb_bitpack_sched.sv
// Scoreboard bench for bitpack_sched: stimulus queues expected grants, words and
// done pulses; independent monitors pop and compare as the DUT presents them.
module tb_bitpack_sched;

  localparam int NREQ = 2;
  localparam int W    = 4;
  localparam int KM   = 8;
  localparam int PW   = 256 * W;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0][3:0] req_npoly = '0;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 rd_en;
  logic                 rd_owner;
  logic [3:0]           rd_idx;
  logic                 rd_valid = 1'b0;
  logic [W-1:0]         rd_data [0:255];
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [PW-1:0]        out_data;
  logic                 out_owner;
  logic [3:0]           out_idx;
  logic                 out_last;
  logic [NREQ-1:0]      done;
`ifdef BITPACK_SCHED_PERF_EN
  logic [31:0]          perf_stall_cnt;
  logic [31:0]          perf_job_cnt;
`endif

  always #5 clk = ~clk;

  bitpack_sched #(.NREQ(NREQ), .W_WIDTH(W), .K_MAX(KM)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_npoly (req_npoly),
    .gnt       (gnt),
    .busy      (busy),
    .rd_en     (rd_en),
    .rd_owner  (rd_owner),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_owner (out_owner),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done)
`ifdef BITPACK_SCHED_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_job_cnt   (perf_job_cnt)
`endif
  );

  typedef struct {
    logic          owner;
    logic [3:0]    idx;
    logic          last;
    logic [PW-1:0] data;
  } word_t;

  typedef struct {
    logic owner;
    logic zero;
  } done_t;

  word_t exp_words[$];
  done_t exp_done[$];
  logic  exp_gnt[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // single-writer control variables
  int want [NREQ]    = '{0, 0};
  int granted [NREQ] = '{0, 0};
  int rd_lat         = 0;
  int bp_target      = 0;
  int bp_used        = 0;
  bit chk_period     = 0;
  int n_xfer         = 0;
  int last_xfer      = 0;
  int gnt_cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic chk_data(input string name, input logic [PW-1:0] act, input logic [PW-1:0] expv);
    int  first;
    bit  found;
    n_checks++;
    if (act === expv) n_pass++;
    else begin
      first = 0;
      found = 0;
      for (int i = 0; i < 256; i++)
        if (!found && (act[i*W +: W] !== expv[i*W +: W])) begin
          first = i;
          found = 1;
        end
      $display("FAIL %s: coeff %0d got %0h required %0h (cycle %0d)",
               name, first, act[first*W +: W], expv[first*W +: W], cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  function automatic logic [PW-1:0] golden(input int o, input int p);
    logic [PW-1:0] w;
    w = '0;
    for (int i = 0; i < 256; i++) w[i*W +: W] = 4'((i + p + 5 * o) % 16);
    return w;
  endfunction

  // Requester side: hold req until as many grants as issued jobs have been seen.
  initial forever begin
    @(negedge clk);
    for (int r = 0; r < NREQ; r++) begin
      if (gnt[r]) granted[r]++;
      req[r] = (granted[r] < want[r]);
    end
  end

  // Coefficient store model with programmable fetch latency.
  initial begin
    int rcnt;
    rcnt = 0;
    for (int i = 0; i < 256; i++) rd_data[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_en) begin
        if (rcnt == rd_lat) begin
          rd_valid = 1'b1;
          for (int i = 0; i < 256; i++) rd_data[i] = 4'((i + int'(rd_idx) + 5 * int'(rd_owner)) % 16);
        end else begin
          rcnt++;
          rd_valid = 1'b0;
        end
      end else begin
        rd_valid = 1'b0;
        rcnt     = 0;
      end
    end
  end

  // Sink: stalls the word with idx 3 for bp_target-bp_used cycles.
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_used < bp_target && out_valid && out_idx == 4'd3) begin
      out_ready = 1'b0;
      bp_used++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Output monitor: every valid cycle compares against the queue head, pops on transfer.
  initial forever begin
    word_t w;
    @(negedge clk);
    if (out_valid) begin
      if (exp_words.size() == 0) fail_now("out_unexpected");
      else begin
        w = exp_words[0];
        chk("out_owner", 64'(out_owner), 64'(w.owner));
        chk("out_idx",   64'(out_idx),   64'(w.idx));
        chk("out_last",  64'(out_last),  64'(w.last));
        chk_data("out_data", out_data, w.data);
        if (out_ready) begin
          void'(exp_words.pop_front());
          if (chk_period && out_idx != 4'd0) chk("poly_period", 64'(cyc - last_xfer), 64'd3);
          last_xfer = cyc;
          n_xfer++;
        end
      end
    end
  end

  // Grant and done monitor.
  initial forever begin
    done_t d;
    logic  o;
    logic [NREQ-1:0] onehot;
    @(negedge clk);
    if (gnt != '0) begin
      if (exp_gnt.size() == 0) fail_now("gnt_unexpected");
      else begin
        o      = exp_gnt.pop_front();
        onehot = NREQ'(1) << o;
        chk("gnt_order", 64'(gnt), 64'(onehot));
        chk("busy_at_gnt", 64'(busy), 64'd1);
        gnt_cyc = cyc;
      end
    end
    if (done != '0) begin
      if (exp_done.size() == 0) fail_now("done_unexpected");
      else begin
        d      = exp_done.pop_front();
        onehot = NREQ'(1) << d.owner;
        chk("done_owner", 64'(done), 64'(onehot));
        chk("done_timing", 64'(cyc), 64'((d.zero ? gnt_cyc : last_xfer) + 1));
      end
    end
  end

  // Fetch timing monitor: rd_en hold length and rd_valid -> out_valid latency.
  initial begin
    int  run;
    int  acc_cyc;
    bit  prev_ov;
    run = 0; acc_cyc = 0; prev_ov = 0;
    forever begin
      @(negedge clk);
      if (rd_en) run++;
      else       run = 0;
      if (rd_en && rd_valid) begin
        chk("rd_en_hold", 64'(run), 64'(rd_lat + 1));
        acc_cyc = cyc;
        run     = 0;
      end
      if (out_valid && !prev_ov) chk("rd_to_out_latency", 64'(cyc - acc_cyc), 64'd2);
      prev_ov = out_valid;
    end
  end

  function automatic logic outputs_nonzero();
    return |{gnt, busy, rd_en, rd_owner, rd_idx, out_valid, out_data, out_owner, out_idx, out_last, done};
  endfunction

  task automatic push_job(input logic o, input int np);
    int n;
    n = (np > KM) ? KM : np;
    exp_gnt.push_back(o);
    for (int p = 0; p < n; p++) exp_words.push_back('{o, 4'(p), (p == n - 1), golden(int'(o), p)});
    exp_done.push_back('{o, (n == 0)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_outputs", 64'(outputs_nonzero()), 64'd0);
    exp_words.delete();
    exp_done.delete();
    exp_gnt.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_words.size() == 0 && exp_done.size() == 0 && exp_gnt.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("timeout_waiting_for_job");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    bit ok;

    // initial reset check
    do_reset();

    // single job, 8 polynomials, zero-wait fetch
    chk_period = 1;
    push_job(1'b0, 8);
    req_npoly[0] = 4'd8;
    want[0]++;
    wait_idle(500);
    chk_period = 0;

    // round-robin: both requesters hold two jobs each
    do_reset();
    push_job(1'b0, 2); push_job(1'b1, 2); push_job(1'b0, 2); push_job(1'b1, 2);
    req_npoly[0] = 4'd2;
    req_npoly[1] = 4'd2;
    want[0] += 2;
    want[1] += 2;
    wait_idle(500);

    // backpressure on idx 3
    do_reset();
    bp_target += 5;
    push_job(1'b1, 6);
    req_npoly[1] = 4'd6;
    want[1]++;
    wait_idle(500);
    chk("bp_stall_consumed", 64'(bp_used), 64'(bp_target));
`ifdef BITPACK_SCHED_PERF_EN
    chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'd5);
    chk("perf_job_cnt",   64'(perf_job_cnt),   64'd1);
`endif

    // fetch latency of 4 cycles
    do_reset();
    rd_lat = 4;
    push_job(1'b0, 3);
    req_npoly[0] = 4'd3;
    want[0]++;
    wait_idle(500);
    rd_lat = 0;

    // npoly = 0 then npoly = 12 clamped to K_MAX
    push_job(1'b1, 0);
    req_npoly[1] = 4'd0;
    want[1]++;
    wait_idle(100);
    push_job(1'b0, 12);
    req_npoly[0] = 4'd12;
    want[0]++;
    wait_idle(500);

    // reset mid-job after idx 2 transfers; leaves rr_ptr at 1 beforehand
    do_reset();
    push_job(1'b0, 8);
    req_npoly[0] = 4'd8;
    want[0]++;
    base = n_xfer;
    ok   = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_xfer >= base + 3) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("timeout_mid_job");
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_mid_job_outputs", 64'(outputs_nonzero()), 64'd0);
    exp_words.delete();
    exp_done.delete();
    exp_gnt.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    push_job(1'b0, 1);
    push_job(1'b1, 1);
    req_npoly[0] = 4'd1;
    req_npoly[1] = 4'd1;
    want[0]++;
    want[1]++;
    wait_idle(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
